// File: rtl/pipe_reg_ctrl.sv
// Stall/flush sequencer driving enable and sync-reset pins of the pipeline registers.
// Optional stall-cycle counter built when PIPE_CTRL_PERF_EN is defined.
module pipe_reg_ctrl #(
    parameter int NREG   = 4,
    parameter int MC_LAT = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_use,
    input  logic            branch_taken,
    input  logic            exception,
    input  logic            ext_stall,
    input  logic            mc_start,
    output logic [NREG-1:0] stage_en,
    output logic [NREG-1:0] stage_flush,
    output logic            pc_en,
    output logic            busy
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0]     stall_cnt
`endif
);

    typedef enum logic {
        RUN    = 1'b0,
        MCBUSY = 1'b1
    } state_t;

    localparam logic [7:0] LP_MC_INIT = 8'(MC_LAT - 1);

    state_t          r_state;
    logic [7:0]      r_cnt;
    state_t          w_nstate;
    logic [7:0]      w_ncnt;
    logic [NREG-1:0] w_en;
    logic [NREG-1:0] w_fl;
    logic            w_pc;

    always_comb begin
        w_en     = '1;
        w_fl     = '0;
        w_pc     = 1'b1;
        w_nstate = r_state;
        w_ncnt   = r_cnt;
        if (!rst) begin
            w_en = '0;
            w_fl = '1;
            w_pc = 1'b0;
        end else if (exception) begin
            w_fl     = '1;
            w_nstate = RUN;
            w_ncnt   = '0;
        end else if (ext_stall) begin
            w_en = '0;
            w_pc = 1'b0;
        end else if (r_state == MCBUSY) begin
            if (r_cnt == 8'd1) begin
                w_nstate = RUN;
                w_ncnt   = '0;
            end else begin
                // Hold IF/ID and ID/EX, feed bubbles into EX/MEM
                w_pc     = 1'b0;
                w_en[0]  = 1'b0;
                w_en[1]  = 1'b0;
                w_fl[2]  = 1'b1;
                w_ncnt   = r_cnt - 8'd1;
            end
        end else if (mc_start) begin
            w_pc     = 1'b0;
            w_en[0]  = 1'b0;
            w_en[1]  = 1'b0;
            w_fl[2]  = 1'b1;
            w_ncnt   = LP_MC_INIT;
            w_nstate = MCBUSY;
        end else if (branch_taken) begin
            w_fl[0] = 1'b1;
            w_fl[1] = 1'b1;
        end else if (load_use) begin
            w_pc    = 1'b0;
            w_en[0] = 1'b0;
            w_fl[1] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_nstate;
            r_cnt   <= w_ncnt;
        end
    end

    assign stage_en    = w_en;
    assign stage_flush = w_fl;
    assign pc_en       = w_pc;
    assign busy        = rst && (r_state == MCBUSY);

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
        end else if (!w_pc && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_pipe_reg_ctrl.sv
// Directed bench for pipe_reg_ctrl (NREG=4, MC_LAT=4).
// Observed vector packs {stage_en, stage_flush, pc_en, busy}.
module tb_pipe_reg_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       load_use = 1'b0;
    logic       branch_taken = 1'b0;
    logic       exception = 1'b0;
    logic       ext_stall = 1'b0;
    logic       mc_start = 1'b0;
    logic [3:0] stage_en;
    logic [3:0] stage_flush;
    logic       pc_en;
    logic       busy;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cnt;
`endif

    logic [9:0] w_obs;
    int total = 0;
    int bad = 0;

    localparam logic [9:0] NORM  = {4'b1111, 4'b0000, 1'b1, 1'b0};
    localparam logic [9:0] NORMB = {4'b1111, 4'b0000, 1'b1, 1'b1};
    localparam logic [9:0] RSTV  = {4'b0000, 4'b1111, 1'b0, 1'b0};
    localparam logic [9:0] MCS   = {4'b1100, 4'b0100, 1'b0, 1'b0};
    localparam logic [9:0] MCSB  = {4'b1100, 4'b0100, 1'b0, 1'b1};
    localparam logic [9:0] EXCB  = {4'b1111, 4'b1111, 1'b1, 1'b1};
    localparam logic [9:0] EXC   = {4'b1111, 4'b1111, 1'b1, 1'b0};
    localparam logic [9:0] BR    = {4'b1111, 4'b0011, 1'b1, 1'b0};
    localparam logic [9:0] LU    = {4'b1110, 4'b0010, 1'b0, 1'b0};
    localparam logic [9:0] FRZB  = {4'b0000, 4'b0000, 1'b0, 1'b1};

    pipe_reg_ctrl #(
        .NREG(4),
        .MC_LAT(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .load_use(load_use),
        .branch_taken(branch_taken),
        .exception(exception),
        .ext_stall(ext_stall),
        .mc_start(mc_start),
        .stage_en(stage_en),
        .stage_flush(stage_flush),
        .pc_en(pc_en),
        .busy(busy)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    assign w_obs = {stage_en, stage_flush, pc_en, busy};

    always #5 clk = ~clk;

    task automatic drive(input logic lu, input logic br, input logic ex,
                         input logic es, input logic mc);
        load_use     = lu;
        branch_taken = br;
        exception    = ex;
        ext_stall    = es;
        mc_start     = mc;
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        total++;
        if (w_obs !== RSTV) begin
            bad++;
            $display("FAIL reset_vec got=%b exp=%b", w_obs, RSTV);
        end
`ifdef PIPE_CTRL_PERF_EN
        total++;
        if (stall_cnt !== 32'd0) begin
            bad++;
            $display("FAIL reset_cnt got=%0d exp=0", stall_cnt);
        end
`endif
        rst = 1'b1;
        #1;
        total++;
        if (w_obs !== NORM) begin
            bad++;
            $display("FAIL reset_release got=%b exp=%b", w_obs, NORM);
        end
        next_cyc();
    endtask

    task automatic test_load_use();
        drive(1, 0, 0, 0, 0);
        @(negedge clk);
        total++;
        if (w_obs !== LU) begin
            bad++;
            $display("FAIL load_use got=%b exp=%b", w_obs, LU);
        end
        next_cyc();
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        total++;
        if (w_obs !== NORM) begin
            bad++;
            $display("FAIL load_use_after got=%b exp=%b", w_obs, NORM);
        end
        next_cyc();
    endtask

    task automatic test_branch();
        drive(0, 1, 0, 0, 0);
        @(negedge clk);
        total++;
        if (w_obs !== BR) begin
            bad++;
            $display("FAIL branch got=%b exp=%b", w_obs, BR);
        end
        next_cyc();
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        total++;
        if (w_obs !== NORM) begin
            bad++;
            $display("FAIL branch_after got=%b exp=%b", w_obs, NORM);
        end
        next_cyc();
    endtask

    task automatic test_multicycle();
        logic [9:0] exp_t [5];
        exp_t = '{MCS, MCSB, MCSB, NORMB, NORM};
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 0, (i < 4) ? 1'b1 : 1'b0);
            @(negedge clk);
            total++;
            if (w_obs !== exp_t[i]) begin
                bad++;
                $display("FAIL mc_c%0d got=%b exp=%b", i + 1, w_obs, exp_t[i]);
            end
            next_cyc();
        end
    endtask

    task automatic test_exception();
        logic [9:0] exp_t [3];
        logic [4:0] vin [3];
        exp_t = '{MCS, EXCB, NORM};
        vin   = '{5'b00001, 5'b00101, 5'b00000};
        for (int i = 0; i < 3; i++) begin
            drive(vin[i][4], vin[i][3], vin[i][2], vin[i][1], vin[i][0]);
            @(negedge clk);
            total++;
            if (w_obs !== exp_t[i]) begin
                bad++;
                $display("FAIL exc_c%0d got=%b exp=%b", i + 1, w_obs, exp_t[i]);
            end
            next_cyc();
        end
    endtask

    task automatic test_ext_stall();
        logic [9:0] exp_t [7];
        logic [4:0] vin [7];
        exp_t = '{MCS, MCSB, FRZB, FRZB, MCSB, NORMB, NORM};
        vin   = '{5'b00001, 5'b00000, 5'b01010, 5'b01010,
                  5'b01000, 5'b00000, 5'b00000};
        for (int i = 0; i < 7; i++) begin
            drive(vin[i][4], vin[i][3], vin[i][2], vin[i][1], vin[i][0]);
            @(negedge clk);
            total++;
            if (w_obs !== exp_t[i]) begin
                bad++;
                $display("FAIL frz_c%0d got=%b exp=%b", i + 1, w_obs, exp_t[i]);
            end
            next_cyc();
        end
    endtask

    task automatic test_priority();
        drive(1, 1, 0, 0, 0);
        @(negedge clk);
        total++;
        if (w_obs !== BR) begin
            bad++;
            $display("FAIL prio_br_lu got=%b exp=%b", w_obs, BR);
        end
        next_cyc();
        drive(1, 1, 1, 1, 1);
        @(negedge clk);
        total++;
        if (w_obs !== EXC) begin
            bad++;
            $display("FAIL prio_exc got=%b exp=%b", w_obs, EXC);
        end
        next_cyc();
        drive(0, 0, 0, 0, 0);
    endtask

`ifdef PIPE_CTRL_PERF_EN
    task automatic test_perf();
        @(negedge clk);
        total++;
        if (stall_cnt !== 32'd10) begin
            bad++;
            $display("FAIL stall_cnt got=%0d exp=10", stall_cnt);
        end
        next_cyc();
    endtask
`endif

    task automatic test_async_reset();
        drive(0, 0, 0, 0, 1);
        next_cyc();
        drive(0, 0, 0, 0, 0);
        #1;
        total++;
        if (w_obs !== MCSB) begin
            bad++;
            $display("FAIL areset_pre got=%b exp=%b", w_obs, MCSB);
        end
        rst = 1'b0;
        #1;
        total++;
        if (w_obs !== RSTV) begin
            bad++;
            $display("FAIL areset_vec got=%b exp=%b", w_obs, RSTV);
        end
`ifdef PIPE_CTRL_PERF_EN
        total++;
        if (stall_cnt !== 32'd0) begin
            bad++;
            $display("FAIL areset_cnt got=%0d exp=0", stall_cnt);
        end
`endif
        next_cyc();
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (w_obs !== NORM) begin
            bad++;
            $display("FAIL areset_release got=%b exp=%b", w_obs, NORM);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_multicycle();
        test_exception();
        test_ext_stall();
        test_priority();
`ifdef PIPE_CTRL_PERF_EN
        test_perf();
`endif
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
